// File: rtl/snitch_shared_muldiv_arbiter.sv
// Shares one MULDIV accelerator among NrCores cores: round-robin request
// arbitration with backpressure lock, per-core credit limit, and a one-entry
// response register that routes results back to the issuing core.
// Optional contention counter: define SNITCH_MULDIV_ARB_PERF_EN.
module snitch_shared_muldiv_arbiter #(
  parameter int unsigned NrCores        = 8,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned CoreIdxW      = (NrCores > 1) ? $clog2(NrCores) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NrCores-1:0]            core_qvalid_i,
  output logic [NrCores-1:0]            core_qready_o,
  input  logic [NrCores*32-1:0]         core_qop_i,
  input  logic [NrCores*DataWidth-1:0]  core_qarga_i,
  input  logic [NrCores*DataWidth-1:0]  core_qargb_i,
  input  logic [NrCores*IdWidth-1:0]    core_qid_i,
  output logic                          muldiv_qvalid_o,
  input  logic                          muldiv_qready_i,
  output logic [31:0]                   muldiv_qop_o,
  output logic [DataWidth-1:0]          muldiv_qarga_o,
  output logic [DataWidth-1:0]          muldiv_qargb_o,
  output logic [CoreIdxW+IdWidth-1:0]   muldiv_qid_o,
  input  logic                          muldiv_pvalid_i,
  output logic                          muldiv_pready_o,
  input  logic [DataWidth-1:0]          muldiv_pdata_i,
  input  logic [CoreIdxW+IdWidth-1:0]   muldiv_pid_i,
  output logic [NrCores-1:0]            core_pvalid_o,
  input  logic [NrCores-1:0]            core_pready_i,
  output logic [DataWidth-1:0]          core_pdata_o,
  output logic [IdWidth-1:0]            core_pid_o,
  output logic [31:0]                   perf_conflict_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [NrCores-1:0][31:0]          qop;
  logic [NrCores-1:0][DataWidth-1:0] qarga, qargb;
  logic [NrCores-1:0][IdWidth-1:0]   qid;

  logic [CoreIdxW-1:0]          rr_q, lock_idx_q, gnt_idx, gnt_lo, gnt_hi;
  logic                         lock_q, lo_found, hi_found;
  logic [NrCores-1:0]           elig;
  logic [NrCores-1:0][CntW-1:0] cnt_q, cnt_d;
  logic                         req_hs, core_hs, resp_legal, resp_capture;
  logic [CoreIdxW-1:0]          resp_pidx;

  logic                         resp_valid_q;
  logic [CoreIdxW-1:0]          resp_idx_q;
  logic [IdWidth-1:0]           resp_id_q;
  logic [DataWidth-1:0]         resp_data_q;

  assign qop   = core_qop_i;
  assign qarga = core_qarga_i;
  assign qargb = core_qargb_i;
  assign qid   = core_qid_i;

  // Eligibility: valid request and a free credit slot.
  always_comb begin
    for (int i = 0; i < NrCores; i++) begin
      elig[i] = core_qvalid_i[i] && (cnt_q[i] < CntW'(MaxOutstanding));
    end
  end

  // Round-robin pick: first eligible at or above rr_q, else lowest eligible.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    gnt_lo   = '0;
    gnt_hi   = '0;
    for (int i = 0; i < NrCores; i++) begin
      if (elig[i] && !lo_found) begin
        lo_found = 1'b1;
        gnt_lo   = CoreIdxW'(i);
      end
      if (elig[i] && !hi_found && (CoreIdxW'(i) >= rr_q)) begin
        hi_found = 1'b1;
        gnt_hi   = CoreIdxW'(i);
      end
    end
    gnt_idx = lock_q ? lock_idx_q : (hi_found ? gnt_hi : gnt_lo);
  end

  assign muldiv_qvalid_o = !rst_i && (lock_q ? elig[lock_idx_q] : lo_found);
  assign muldiv_qop_o    = qop[gnt_idx];
  assign muldiv_qarga_o  = qarga[gnt_idx];
  assign muldiv_qargb_o  = qargb[gnt_idx];
  assign muldiv_qid_o    = {gnt_idx, qid[gnt_idx]};
  assign req_hs          = muldiv_qvalid_o && muldiv_qready_i;

  // Ready goes only to the granted core.
  always_comb begin
    core_qready_o          = '0;
    core_qready_o[gnt_idx] = muldiv_qvalid_o && muldiv_qready_i;
  end

  // Response side: one-entry register, refillable in the cycle it drains.
  assign resp_pidx       = muldiv_pid_i[CoreIdxW+IdWidth-1 -: CoreIdxW];
  assign resp_legal      = (32'(resp_pidx) < NrCores);
  assign core_hs         = resp_valid_q && core_pready_i[resp_idx_q];
  assign muldiv_pready_o = !resp_valid_q || core_hs;
  assign resp_capture    = muldiv_pvalid_i && muldiv_pready_o && resp_legal;
  assign core_pvalid_o   = NrCores'(resp_valid_q) << resp_idx_q;
  assign core_pdata_o    = resp_data_q;
  assign core_pid_o      = resp_id_q;

  // Credit update: +1 on issue, -1 on delivery, saturating at zero.
  always_comb begin
    for (int i = 0; i < NrCores; i++) begin
      cnt_d[i] = cnt_q[i];
      if (req_hs && (gnt_idx == CoreIdxW'(i)) && !(core_pvalid_o[i] && core_pready_i[i])) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!(req_hs && (gnt_idx == CoreIdxW'(i))) && core_pvalid_o[i] &&
                   core_pready_i[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Arbiter pointer, lock, credits and response register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q         <= '0;
      lock_q       <= 1'b0;
      lock_idx_q   <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= muldiv_qvalid_o && !muldiv_qready_i;
      if (muldiv_qvalid_o && !muldiv_qready_i) lock_idx_q <= gnt_idx;
      if (req_hs) begin
        rr_q <= (gnt_idx == CoreIdxW'(NrCores - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (resp_capture) begin
        resp_valid_q <= 1'b1;
        resp_idx_q   <= resp_pidx;
        resp_id_q    <= muldiv_pid_i[IdWidth-1:0];
        resp_data_q  <= muldiv_pdata_i;
      end else if (core_hs) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

`ifdef SNITCH_MULDIV_ARB_PERF_EN
  logic [31:0] perf_q;
  logic        seen_one, seen_two;

  // Detect two or more simultaneously eligible cores.
  always_comb begin
    seen_one = 1'b0;
    seen_two = 1'b0;
    for (int i = 0; i < NrCores; i++) begin
      if (elig[i]) begin
        seen_two = seen_two || seen_one;
        seen_one = 1'b1;
      end
    end
  end

  // Wrapping contention counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) perf_q <= '0;
    else if (seen_two) perf_q <= perf_q + 32'd1;
  end

  assign perf_conflict_o = perf_q;
`else
  assign perf_conflict_o = '0;
`endif

`ifndef SYNTHESIS
  a_lock_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    lock_q |-> core_qvalid_i[lock_idx_q]);
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    core_hs |-> ((cnt_q[resp_idx_q] != '0) || (req_hs && (gnt_idx == resp_idx_q))));
  a_legal_resp_idx: assert property (@(posedge clk_i) disable iff (rst_i)
    (muldiv_pvalid_i && muldiv_pready_o) |-> resp_legal);
`endif

endmodule

// File: tb/tb_snitch_shared_muldiv_arbiter.sv
// Directed bench for snitch_shared_muldiv_arbiter (8 cores, 32-bit data).
module tb_snitch_shared_muldiv_arbiter;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      core_qvalid;
  logic [N-1:0]      core_qready;
  logic [N*32-1:0]   core_qop;
  logic [N*DW-1:0]   core_qarga, core_qargb;
  logic [N*IW-1:0]   core_qid;
  logic              muldiv_qvalid, muldiv_qready;
  logic [31:0]       muldiv_qop;
  logic [DW-1:0]     muldiv_qarga, muldiv_qargb;
  logic [CW+IW-1:0]  muldiv_qid;
  logic              muldiv_pvalid, muldiv_pready;
  logic [DW-1:0]     muldiv_pdata;
  logic [CW+IW-1:0]  muldiv_pid;
  logic [N-1:0]      core_pvalid, core_pready;
  logic [DW-1:0]     core_pdata;
  logic [IW-1:0]     core_pid;
  logic [31:0]       perf;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  snitch_shared_muldiv_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .core_qvalid_i(core_qvalid), .core_qready_o(core_qready),
    .core_qop_i(core_qop), .core_qarga_i(core_qarga), .core_qargb_i(core_qargb),
    .core_qid_i(core_qid),
    .muldiv_qvalid_o(muldiv_qvalid), .muldiv_qready_i(muldiv_qready),
    .muldiv_qop_o(muldiv_qop), .muldiv_qarga_o(muldiv_qarga), .muldiv_qargb_o(muldiv_qargb),
    .muldiv_qid_o(muldiv_qid),
    .muldiv_pvalid_i(muldiv_pvalid), .muldiv_pready_o(muldiv_pready),
    .muldiv_pdata_i(muldiv_pdata), .muldiv_pid_i(muldiv_pid),
    .core_pvalid_o(core_pvalid), .core_pready_i(core_pready),
    .core_pdata_o(core_pdata), .core_pid_o(core_pid),
    .perf_conflict_o(perf)
  );

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle inputs, per-core payloads and a one-clock reset pulse.
  task automatic apply_reset();
    rst           = 1'b1;
    core_qvalid   = '0;
    muldiv_qready = 1'b0;
    muldiv_pvalid = 1'b0;
    muldiv_pdata  = '0;
    muldiv_pid    = '0;
    core_pready   = '1;
    for (int i = 0; i < N; i++) begin
      core_qop[i*32 +: 32]   = 32'h1000_0000 + i;
      core_qarga[i*DW +: DW] = 32'hA000_0000 + i;
      core_qargb[i*DW +: DW] = 32'hB000_0000 + i;
      core_qid[i*IW +: IW]   = IW'(i);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    core_qvalid   = '1;
    muldiv_qready = 1'b1;
    #1;
    total++; if (muldiv_qvalid !== 1'b0) $display("FAIL reset_qvalid: got %b want 0", muldiv_qvalid); else passed++;
    total++; if (core_qready !== 8'h00) $display("FAIL reset_qready: got %h want 00", core_qready); else passed++;
    total++; if (core_pvalid !== 8'h00) $display("FAIL reset_pvalid: got %h want 00", core_pvalid); else passed++;
    total++; if (muldiv_pready !== 1'b1) $display("FAIL reset_pready: got %b want 1", muldiv_pready); else passed++;
    total++; if (perf !== 32'd0) $display("FAIL reset_perf: got %0d want 0", perf); else passed++;
    step();
    core_qvalid = '0;
    muldiv_qready = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_transfer();
    apply_reset();
    core_qvalid = 8'b0000_0100;
    muldiv_qready = 1'b1;
    repeat (3) step();
    core_qvalid = 8'b0000_1100;
    muldiv_qready = 1'b0;
    #1;
    total++; if (muldiv_qid[7:5] !== 3'd3) $display("FAIL mid_pre_grant: got %0d want 3", muldiv_qid[7:5]); else passed++;
    step();
    rst = 1'b1;
    #1;
    total++; if (muldiv_qvalid !== 1'b0) $display("FAIL mid_rst_qvalid: got %b want 0", muldiv_qvalid); else passed++;
    total++; if (core_pvalid !== 8'h00) $display("FAIL mid_rst_pvalid: got %h want 00", core_pvalid); else passed++;
    total++; if (muldiv_pready !== 1'b1) $display("FAIL mid_rst_pready: got %b want 1", muldiv_pready); else passed++;
    step();
    rst = 1'b0;
    core_qvalid = 8'b0000_0101;
    muldiv_qready = 1'b1;
    #1;
    total++; if (muldiv_qid[7:5] !== 3'd0) $display("FAIL mid_first_grant: got %0d want 0", muldiv_qid[7:5]); else passed++;
    step();
    #1;
    total++; if (muldiv_qid[7:5] !== 3'd2) $display("FAIL mid_second_grant: got %0d want 2", muldiv_qid[7:5]); else passed++;
    step();
    core_qvalid = 8'b0000_0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (core_qready !== 8'b0000_0100) $display("FAIL mid_credit_%0d: got %h want 04", k, core_qready); else passed++;
      step();
    end
    core_qvalid = '0;
  endtask

  task automatic test_single_core();
    apply_reset();
    core_qid[3*IW +: IW] = 5'd5;
    core_qvalid = 8'b0000_1000;
    muldiv_qready = 1'b1;
    #1;
    total++; if (muldiv_qvalid !== 1'b1) $display("FAIL single_qvalid: got %b want 1", muldiv_qvalid); else passed++;
    total++; if (muldiv_qid !== 8'h65) $display("FAIL single_qid: got %h want 65", muldiv_qid); else passed++;
    total++; if (muldiv_qop !== 32'h1000_0003) $display("FAIL single_qop: got %h want 10000003", muldiv_qop); else passed++;
    total++; if (muldiv_qargb !== 32'hB000_0003) $display("FAIL single_argb: got %h want b0000003", muldiv_qargb); else passed++;
    total++; if (core_qready !== 8'b0000_1000) $display("FAIL single_qready: got %h want 08", core_qready); else passed++;
    step();
    core_qvalid = '0;
    muldiv_pvalid = 1'b1;
    muldiv_pid = 8'h65;
    muldiv_pdata = 32'hDEAD_BEEF;
    #1;
    total++; if (muldiv_pready !== 1'b1) $display("FAIL single_pready: got %b want 1", muldiv_pready); else passed++;
    total++; if (core_pvalid !== 8'h00) $display("FAIL single_pvalid_early: got %h want 00", core_pvalid); else passed++;
    step();
    muldiv_pvalid = 1'b0;
    #1;
    total++; if (core_pvalid !== 8'b0000_1000) $display("FAIL single_pvalid: got %h want 08", core_pvalid); else passed++;
    total++; if (core_pdata !== 32'hDEAD_BEEF) $display("FAIL single_pdata: got %h want deadbeef", core_pdata); else passed++;
    total++; if (core_pid !== 5'd5) $display("FAIL single_pid: got %0d want 5", core_pid); else passed++;
    step();
    #1;
    total++; if (core_pvalid !== 8'h00) $display("FAIL single_pvalid_drain: got %h want 00", core_pvalid); else passed++;
  endtask

  task automatic test_fairness();
    int exp_perf;
    apply_reset();
    core_qvalid = '1;
    muldiv_qready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      total++; if (muldiv_qid[7:5] !== 3'(k % 8)) $display("FAIL fair_grant_%0d: got %0d want %0d", k, muldiv_qid[7:5], k % 8); else passed++;
`ifdef SNITCH_MULDIV_ARB_PERF_EN
      exp_perf = k;
`else
      exp_perf = 0;
`endif
      total++; if (perf !== 32'(exp_perf)) $display("FAIL fair_perf_%0d: got %0d want %0d", k, perf, exp_perf); else passed++;
      step();
    end
    core_qvalid = '0;
  endtask

  task automatic test_backpressure_lock();
    apply_reset();
    core_qvalid = 8'b0000_0110;
    muldiv_qready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) core_qvalid = 8'b0000_0111;
      #1;
      total++; if (muldiv_qid[7:5] !== 3'd1) $display("FAIL lock_grant_%0d: got %0d want 1", k, muldiv_qid[7:5]); else passed++;
      total++; if (muldiv_qop !== 32'h1000_0001) $display("FAIL lock_op_%0d: got %h want 10000001", k, muldiv_qop); else passed++;
      total++; if (core_qready !== 8'h00) $display("FAIL lock_qready_%0d: got %h want 00", k, core_qready); else passed++;
      step();
    end
    muldiv_qready = 1'b1;
    #1;
    total++; if (core_qready !== 8'b0000_0010) $display("FAIL lock_release: got %h want 02", core_qready); else passed++;
    step();
    core_qvalid = 8'b0000_0101;
    #1;
    total++; if (muldiv_qid[7:5] !== 3'd2) $display("FAIL lock_next: got %0d want 2", muldiv_qid[7:5]); else passed++;
    step();
    core_qvalid = '0;
  endtask

  task automatic test_credit_limit();
    apply_reset();
    core_qvalid = 8'b0000_0001;
    muldiv_qready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (core_qready !== 8'h01) $display("FAIL credit_issue_%0d: got %h want 01", k, core_qready); else passed++;
      step();
    end
    #1;
    total++; if (core_qready !== 8'h00) $display("FAIL credit_block: got %h want 00", core_qready); else passed++;
    total++; if (muldiv_qvalid !== 1'b0) $display("FAIL credit_qvalid: got %b want 0", muldiv_qvalid); else passed++;
    muldiv_pvalid = 1'b1;
    muldiv_pid = 8'h00;
    muldiv_pdata = 32'h0000_1234;
    step();
    muldiv_pvalid = 1'b0;
    #1;
    total++; if (core_pvalid !== 8'h01) $display("FAIL credit_resp: got %h want 01", core_pvalid); else passed++;
    total++; if (core_qready !== 8'h00) $display("FAIL credit_still_block: got %h want 00", core_qready); else passed++;
    step();
    #1;
    total++; if (core_qready !== 8'h01) $display("FAIL credit_regrant: got %h want 01", core_qready); else passed++;
    step();
    core_qvalid = '0;
  endtask

  task automatic test_back_to_back_resp();
    apply_reset();
    core_qvalid = 8'b0000_0010;
    muldiv_qready = 1'b1;
    repeat (2) step();
    core_qvalid = '0;
    core_pready = 8'b1111_1101;
    muldiv_pvalid = 1'b1;
    muldiv_pid = 8'h21;
    muldiv_pdata = 32'h1111_1111;
    #1;
    total++; if (muldiv_pready !== 1'b1) $display("FAIL bp_pready_empty: got %b want 1", muldiv_pready); else passed++;
    step();
    muldiv_pdata = 32'h2222_2222;
    #1;
    total++; if (muldiv_pready !== 1'b0) $display("FAIL bp_pready_full: got %b want 0", muldiv_pready); else passed++;
    total++; if (core_pvalid !== 8'h02) $display("FAIL bp_pvalid: got %h want 02", core_pvalid); else passed++;
    step();
    #1;
    total++; if (core_pdata !== 32'h1111_1111) $display("FAIL bp_hold_data: got %h want 11111111", core_pdata); else passed++;
    total++; if (muldiv_pready !== 1'b0) $display("FAIL bp_pready_hold: got %b want 0", muldiv_pready); else passed++;
    core_pready = '1;
    #1;
    total++; if (muldiv_pready !== 1'b1) $display("FAIL bp_pready_release: got %b want 1", muldiv_pready); else passed++;
    step();
    muldiv_pvalid = 1'b0;
    #1;
    total++; if (core_pvalid !== 8'h02) $display("FAIL bp_pvalid_second: got %h want 02", core_pvalid); else passed++;
    total++; if (core_pdata !== 32'h2222_2222) $display("FAIL bp_data_second: got %h want 22222222", core_pdata); else passed++;
    step();
    #1;
    total++; if (core_pvalid !== 8'h00) $display("FAIL bp_drain: got %h want 00", core_pvalid); else passed++;
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_single_core();
    test_fairness();
    test_backpressure_lock();
    test_credit_limit();
    test_back_to_back_resp();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
